csnn_conv_lif: RTL and testbench

//  2x2 convolution + leaky integrate-and-fire layer consuming the 64-bit receptive-field code of the coding stage.

---
 rtl/csnn_pkg.sv | 28 ++
 rtl/lif_neuron.sv | 47 ++++
 rtl/csnn_conv_lif.sv | 167 ++++++++++++++++
 tb/tb_csnn_conv_lif.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/csnn_pkg.sv
// Shared definitions for the convolution + LIF layer.
// Contents: receptive-field geometry, pixel bit positions inside a 4-bit field,
// the input-current width, the FSM state type and the default 2x2 kernel set.
package csnn_pkg;

    localparam int unsigned FIELD_W    = 4;
    localparam int unsigned NUM_FIELDS = 16;

    // Pixel positions inside one field (bit index == pixel index p of the weights)
    localparam int unsigned PIX_TL = 3;
    localparam int unsigned PIX_TR = 2;
    localparam int unsigned PIX_BL = 1;
    localparam int unsigned PIX_BR = 0;

    // Sum of four signed 4-bit weights always fits in 6 signed bits
    localparam int unsigned CUR_W = 6;

    // Kernel k, pixel p at [k*16 + p*4 +: 4]
    localparam logic [63:0] DEFAULT_WEIGHTS = 64'h3DD3_3D3D_33DD_2222;

    typedef enum logic [1:0] {
        StIdle,
        StSweep,
        StEmit,
        StDone
    } state_e;

endpackage

// File: rtl/lif_neuron.sv
// Combinational leaky integrate-and-fire update for one membrane.
// Ports:
//   v       in  VW     current membrane potential (never negative in practice)
//   i       in  CUR_W  signed input current for this field
//   thresh  in  VW     firing threshold (spike when updated V >= thresh)
//   v_next  out VW     membrane value to write back (0 after a spike)
//   spike   out 1      neuron fired this update
module lif_neuron
    import csnn_pkg::*;
#(
    parameter int unsigned VW         = 8,
    parameter int unsigned LEAK_SHIFT = 1
) (
    input  logic signed [VW-1:0]    v,
    input  logic signed [CUR_W-1:0] i,
    input  logic signed [VW-1:0]    thresh,
    output logic signed [VW-1:0]    v_next,
    output logic                    spike
);

    // Wide enough that leak + current can never wrap before saturation
    localparam int unsigned SW = VW + CUR_W;
    localparam logic signed [SW-1:0] VMAX = SW'((64'd1 << (VW - 1)) - 64'd1);

    logic signed [SW-1:0] v_ext;
    logic signed [SW-1:0] i_ext;
    logic signed [SW-1:0] sum;
    logic signed [VW-1:0] v_sat;

    always_comb begin
        v_ext = {{CUR_W{v[VW-1]}}, v};
        i_ext = {{VW{i[CUR_W-1]}}, i};
        sum   = v_ext - (v_ext >>> LEAK_SHIFT) + i_ext;

        if (sum < 0) begin
            v_sat = '0;
        end else if (sum > VMAX) begin
            v_sat = VMAX[VW-1:0];
        end else begin
            v_sat = sum[VW-1:0];
        end

        spike  = (v_sat >= thresh);
        v_next = spike ? '0 : v_sat;
    end

endmodule

// File: rtl/csnn_conv_lif.sv
// 2x2 convolution + leaky integrate-and-fire layer.
// Sweeps the 16 receptive fields of a latched 64-bit code one field per cycle, all kernels
// in parallel, for NUM_STEPS timesteps; emits a spike map per step and spike counts at the end.
// Ports:
//   clk        in  1               clock
//   rst        in  1               synchronous reset, active-high
//   start      in  1               start request, only looked at in idle
//   code_in    in  64              field f at [63-4f -: 4] (bit3=TL .. bit0=BR)
//   busy       out 1               inference in progress (sweep/emit)
//   step_valid out 1               one-cycle pulse per completed timestep
//   spike_map  out 16*NUM_KERNELS  bit k*16+f: kernel k fired at field f; valid with step_valid
//   done       out 1               one-cycle pulse at end of inference
//   spike_cnt  out 8*NUM_KERNELS   per-kernel spike totals at [k*8 +: 8]
module csnn_conv_lif
    import csnn_pkg::*;
#(
    parameter int unsigned                 NUM_KERNELS = 4,
    parameter logic [16*NUM_KERNELS-1:0]   WEIGHTS     = DEFAULT_WEIGHTS,
    parameter int unsigned                 VW          = 8,
    parameter logic signed [VW-1:0]        THRESH      = 8'sd4,
    parameter int unsigned                 LEAK_SHIFT  = 1,
    parameter int unsigned                 NUM_STEPS   = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic [63:0]                   code_in,
    output logic                          busy,
    output logic                          step_valid,
    output logic [16*NUM_KERNELS-1:0]     spike_map,
    output logic                          done,
    output logic [8*NUM_KERNELS-1:0]      spike_cnt
);

    state_e state_q, state_d;

    logic [63:0]                 code_q;
    logic [3:0]                  field_q;
    logic [3:0]                  step_q;
    logic [16*NUM_KERNELS-1:0]   map_q;
    logic [8*NUM_KERNELS-1:0]    cnt_q;
    logic signed [VW-1:0]        mem_q [NUM_KERNELS][NUM_FIELDS];

    logic [FIELD_W-1:0]          fields [NUM_FIELDS];
    logic [FIELD_W-1:0]          cur_fld;
    logic signed [CUR_W-1:0]     cur_i  [NUM_KERNELS];
    logic signed [VW-1:0]        v_next [NUM_KERNELS];
    logic [NUM_KERNELS-1:0]      spk;

    // Contribution of pixel p to kernel k: its weight if the pixel is set, else 0
    function automatic logic signed [CUR_W-1:0] wterm(input logic [FIELD_W-1:0] fld,
                                                      input int unsigned k,
                                                      input int unsigned p);
        logic [3:0] w;
        w = WEIGHTS[k*16 + p*4 +: 4];
        return fld[p] ? {{(CUR_W-4){w[3]}}, w} : '0;
    endfunction

    // Field 0 sits in the top nibble of the code
    always_comb begin
        for (int f = 0; f < NUM_FIELDS; f++) begin
            fields[f] = code_q[(NUM_FIELDS-1-f)*FIELD_W +: FIELD_W];
        end
        cur_fld = fields[field_q];
    end

    always_comb begin
        for (int k = 0; k < NUM_KERNELS; k++) begin
            cur_i[k] = wterm(cur_fld, k, PIX_TL) + wterm(cur_fld, k, PIX_TR)
                     + wterm(cur_fld, k, PIX_BL) + wterm(cur_fld, k, PIX_BR);
        end
    end

    for (genvar k = 0; k < NUM_KERNELS; k++) begin : g_lif
        lif_neuron #(
            .VW         (VW),
            .LEAK_SHIFT (LEAK_SHIFT)
        ) u_lif (
            .v      (mem_q[k][field_q]),
            .i      (cur_i[k]),
            .thresh (THRESH),
            .v_next (v_next[k]),
            .spike  (spk[k])
        );
    end

    // Next state and decoded outputs
    always_comb begin
        state_d    = state_q;
        busy       = 1'b0;
        step_valid = 1'b0;
        done       = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) state_d = StSweep;
            end
            StSweep: begin
                busy = 1'b1;
                if (field_q == 4'(NUM_FIELDS - 1)) state_d = StEmit;
            end
            StEmit: begin
                busy       = 1'b1;
                step_valid = 1'b1;
                state_d    = (step_q == 4'(NUM_STEPS - 1)) ? StDone : StSweep;
            end
            StDone: begin
                done    = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            code_q  <= '0;
            field_q <= '0;
            step_q  <= '0;
            map_q   <= '0;
            cnt_q   <= '0;
            for (int k = 0; k < NUM_KERNELS; k++) begin
                for (int f = 0; f < NUM_FIELDS; f++) begin
                    mem_q[k][f] <= '0;
                end
            end
        end else begin
            state_q <= state_d;
            case (state_q)
                StIdle: begin
                    if (start) begin
                        code_q  <= code_in;
                        field_q <= '0;
                        step_q  <= '0;
                        map_q   <= '0;
                        cnt_q   <= '0;
                        for (int k = 0; k < NUM_KERNELS; k++) begin
                            for (int f = 0; f < NUM_FIELDS; f++) begin
                                mem_q[k][f] <= '0;
                            end
                        end
                    end
                end
                StSweep: begin
                    // field_q wraps to 0 after field 15, ready for the next step
                    field_q <= field_q + 4'd1;
                    for (int k = 0; k < NUM_KERNELS; k++) begin
                        mem_q[k][field_q] <= v_next[k];
                        if (spk[k]) begin
                            map_q[k*NUM_FIELDS + int'(field_q)] <= 1'b1;
                            cnt_q[k*8 +: 8] <= cnt_q[k*8 +: 8] + 8'd1;
                        end
                    end
                end
                StEmit: begin
                    map_q  <= '0;
                    step_q <= step_q + 4'd1;
                end
                default: ;
            endcase
        end
    end

    assign spike_map = map_q;
    assign spike_cnt = cnt_q;

endmodule

// File: tb/tb_csnn_conv_lif.sv
module tb_csnn_conv_lif;

    localparam int NS = 4;
    localparam int NK = 4;
    localparam int LAST = 17 * NS + 1;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [63:0] code_in;
    logic        busy;
    logic        step_valid;
    logic [63:0] spike_map;
    logic        done;
    logic [31:0] spike_cnt;

    int n_total = 0;
    int n_pass  = 0;

    always #5 clk = ~clk;

    csnn_conv_lif dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .code_in    (code_in),
        .busy       (busy),
        .step_valid (step_valid),
        .spike_map  (spike_map),
        .done       (done),
        .spike_cnt  (spike_cnt)
    );

    typedef struct {
        logic [63:0]       code;
        logic [3:0][63:0]  maps;
        logic [31:0]       cnt;
    } vec_t;

    vec_t tbl [5];

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    // Reference: straight from the layer's arithmetic rules, on integers
    function automatic int weight(input int k, input int p);
        logic [63:0] wall;
        logic [3:0]  nib;
        wall = 64'h3DD3_3D3D_33DD_2222;
        nib  = wall[k*16 + p*4 +: 4];
        return nib[3] ? int'(nib) - 16 : int'(nib);
    endfunction

    function automatic void model(input logic [63:0] code, output logic [3:0][63:0] maps,
                                  output logic [31:0] cnt);
        int v [NK][16];
        int c [NK];
        logic [3:0] fld;
        int cur, nv;
        maps = '0;
        for (int k = 0; k < NK; k++) begin
            c[k] = 0;
            for (int f = 0; f < 16; f++) v[k][f] = 0;
        end
        for (int s = 0; s < NS; s++) begin
            for (int f = 0; f < 16; f++) begin
                fld = code[63 - 4*f -: 4];
                for (int k = 0; k < NK; k++) begin
                    cur = 0;
                    for (int p = 0; p < 4; p++) if (fld[p]) cur += weight(k, p);
                    nv = v[k][f] - (v[k][f] >>> 1) + cur;
                    if (nv > 127) nv = 127;
                    if (nv < 0) nv = 0;
                    if (nv >= 4) begin
                        maps[s][k*16 + f] = 1'b1;
                        c[k]++;
                        v[k][f] = 0;
                    end else begin
                        v[k][f] = nv;
                    end
                end
            end
        end
        for (int k = 0; k < NK; k++) cnt[k*8 +: 8] = 8'(c[k]);
    endfunction

    // Entered #1 after a posedge with the DUT idle; returns likewise.
    task automatic run(input string name, input logic [63:0] code,
                       input logic [3:0][63:0] maps, input logic [31:0] cnt, input int repulse);
        logic exp_sv, exp_done, exp_busy;
        code_in = code;
        start   = 1'b1;
        @(posedge clk); #1;
        start   = 1'b0;
        code_in = ~code;  // post-acceptance changes must not matter
        for (int c = 1; c <= LAST; c++) begin
            exp_sv   = (c % 17 == 0) && (c <= 17 * NS);
            exp_done = (c == LAST);
            exp_busy = (c <= 17 * NS);
            check($sformatf("%s ctl@%0d", name, c), {61'd0, busy, step_valid, done},
                  {61'd0, exp_busy, exp_sv, exp_done});
            if (exp_sv) check($sformatf("%s map%0d", name, c / 17), spike_map, maps[c / 17 - 1]);
            if (exp_done) begin
                check($sformatf("%s cnt", name), {32'd0, spike_cnt}, {32'd0, cnt});
                start = 1'b1;  // start in the done cycle must be ignored
            end else if (c == repulse) begin
                start   = 1'b1;
                code_in = 64'hFFFF_FFFF_FFFF_FFFF;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
        end
        start = 1'b0;
        check($sformatf("%s post", name), {61'd0, busy, step_valid, done}, 64'd0);
        check($sformatf("%s cnt hold", name), {32'd0, spike_cnt}, {32'd0, cnt});
        @(posedge clk); #1;
    endtask

    initial begin
        logic [3:0][63:0] mm;
        logic [31:0]      mc;
        logic [63:0]      rc;

        tbl[0].code = 64'h0;
        tbl[0].maps = '0;
        tbl[0].cnt  = 32'h0000_0000;

        tbl[1].code = 64'hFFFF_FFFF_FFFF_FFFF;
        for (int s = 0; s < 4; s++) tbl[1].maps[s] = 64'h0000_0000_0000_FFFF;
        tbl[1].cnt  = 32'h0000_0040;

        tbl[2].code = 64'hC000_0000_0000_0000;
        for (int s = 0; s < 4; s++) tbl[2].maps[s] = 64'h0000_0000_0001_0001;
        tbl[2].cnt  = 32'h0000_0404;

        tbl[3].code    = 64'h8000_0000_0000_0000;
        tbl[3].maps[0] = 64'h0;
        tbl[3].maps[1] = 64'h0001_0001_0001_0000;
        tbl[3].maps[2] = 64'h0000_0000_0000_0001;
        tbl[3].maps[3] = 64'h0001_0001_0001_0000;
        tbl[3].cnt     = 32'h0202_0201;

        tbl[4].code = 64'h3000_0000_0000_0000;
        for (int s = 0; s < 4; s++) tbl[4].maps[s] = 64'h0000_0000_0000_0001;
        tbl[4].cnt  = 32'h0000_0004;

        rst = 1'b1; start = 1'b0; code_in = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset ctl", {61'd0, busy, step_valid, done}, 64'd0);
        check("reset map", spike_map, 64'd0);
        check("reset cnt", {32'd0, spike_cnt}, 64'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        for (int t = 0; t < 5; t++) run($sformatf("vec%0d", t), tbl[t].code, tbl[t].maps,
                                        tbl[t].cnt, 0);

        // start re-pulsed mid-sweep with a different code
        run("repulse", tbl[2].code, tbl[2].maps, tbl[2].cnt, 5);

        // reset in the middle of step 2
        code_in = tbl[2].code;
        start   = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (19) @(posedge clk);
        #1;
        check("pre-rst cnt", {32'd0, spike_cnt}, 64'h0000_0202);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("rst ctl", {61'd0, busy, step_valid, done}, 64'd0);
        check("rst map", spike_map, 64'd0);
        check("rst cnt", {32'd0, spike_cnt}, 64'd0);
        for (int c = 0; c < 80; c++) begin
            check($sformatf("after rst @%0d", c), {61'd0, busy, step_valid, done}, 64'd0);
            @(posedge clk); #1;
        end
        run("after rst", tbl[2].code, tbl[2].maps, tbl[2].cnt, 0);

        // randomized codes against the model, dense and sparse
        for (int r = 0; r < 8; r++) begin
            rc = {$urandom, $urandom};
            if (r % 2 == 1) rc = rc & {$urandom, $urandom};
            model(rc, mm, mc);
            run($sformatf("rnd%0d", r), rc, mm, mc, 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
